// File: rtl/rgb2luma_pipe_if.sv
// Pixel-in / luma-out stream bundle for the luma converter.
// The slave modport is the converter's view; the master modport is the
// view of whatever sits around it (pixel source plus downstream sink).
`timescale 1ns/1ps
interface rgb2luma_pipe_if #(
   parameter int WIDTH_P  = 8,
   parameter int COEF_W_P = 8,
   parameter int USER_W_P = 2
);
   logic                valid_i;
   logic                ready_o;
   logic [WIDTH_P-1:0]  red_i;
   logic [WIDTH_P-1:0]  green_i;
   logic [WIDTH_P-1:0]  blue_i;
   logic [1:0]          mode_i;
   logic [COEF_W_P-1:0] coef_r_i;
   logic [COEF_W_P-1:0] coef_g_i;
   logic [COEF_W_P-1:0] coef_b_i;
   logic [USER_W_P-1:0] user_i;
   logic                valid_o;
   logic                ready_i;
   logic [WIDTH_P-1:0]  luma_o;
   logic [USER_W_P-1:0] user_o;

   modport master (
      output valid_i, red_i, green_i, blue_i, mode_i,
             coef_r_i, coef_g_i, coef_b_i, user_i, ready_i,
      input  ready_o, valid_o, luma_o, user_o
   );

   modport slave (
      input  valid_i, red_i, green_i, blue_i, mode_i,
             coef_r_i, coef_g_i, coef_b_i, user_i, ready_i,
      output ready_o, valid_o, luma_o, user_o
   );
endinterface

// File: rtl/rgb2luma_pipe.sv
// Three-stage pipelined RGB-to-luma converter with per-beat coefficient
// selection, round-to-nearest, output saturation and an aligned sideband.
// Stage 1 holds the three channel products, stage 2 their sum, stage 3 the
// rounded and clipped luma. Each stage loads when empty or when its current
// contents move on, so bubbles collapse under downstream stall.
`timescale 1ns/1ps
module rgb2luma_pipe #(
   parameter int WIDTH_P  = 8,
   parameter int COEF_W_P = 8,
   parameter int USER_W_P = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   rgb2luma_pipe_if.slave bus
);

   localparam int PROD_W = WIDTH_P + COEF_W_P;
   localparam int SUM_W  = PROD_W + 2;
   localparam int LUMA_W = SUM_W - COEF_W_P;

   localparam logic [SUM_W-1:0]  ROUND_C = SUM_W'(1) << (COEF_W_P - 1);
   localparam logic [LUMA_W-1:0] MAX_C   = LUMA_W'((1 << WIDTH_P) - 1);

   // Rescale an 8-bit reference coefficient to COEF_W_P bits, truncating
   function automatic logic [COEF_W_P-1:0] scale_coef(input int base);
      int scaled;
      if (COEF_W_P >= 8) begin
         scaled = base << (COEF_W_P - 8);
      end else begin
         scaled = base >> (8 - COEF_W_P);
      end
      return COEF_W_P'(scaled);
   endfunction

   localparam logic [COEF_W_P-1:0] C601_R = scale_coef(77);
   localparam logic [COEF_W_P-1:0] C601_G = scale_coef(150);
   localparam logic [COEF_W_P-1:0] C601_B = scale_coef(29);
   localparam logic [COEF_W_P-1:0] C709_R = scale_coef(54);
   localparam logic [COEF_W_P-1:0] C709_G = scale_coef(183);
   localparam logic [COEF_W_P-1:0] C709_B = scale_coef(19);
   localparam logic [COEF_W_P-1:0] CEQ_R  = scale_coef(85);
   localparam logic [COEF_W_P-1:0] CEQ_G  = scale_coef(86);
   localparam logic [COEF_W_P-1:0] CEQ_B  = scale_coef(85);

   // Stage valids and handshake
   logic v1, v2, v3;
   logic load1, load2, load3;

   // Coefficients chosen for the beat currently on the input
   logic [COEF_W_P-1:0] coef_r, coef_g, coef_b;

   // Stage 1 payload
   logic [PROD_W-1:0]   prod_r_q, prod_g_q, prod_b_q;
   logic [USER_W_P-1:0] user1_q;

   // Stage 2 payload
   logic [SUM_W-1:0]    sum_q;
   logic [USER_W_P-1:0] user2_q;

   // Stage 3 (output) registers
   logic [WIDTH_P-1:0]  luma_q;
   logic [USER_W_P-1:0] user3_q;

   // Rounding and clipping of the stage 2 sum
   logic [LUMA_W-1:0]   unclipped;
   logic [WIDTH_P-1:0]  luma_next;

   // A stage loads when it is empty or its occupant leaves this cycle
   assign load3 = ~v3 | bus.ready_i;
   assign load2 = ~v2 | load3;
   assign load1 = ~v1 | load2;

   assign bus.ready_o = load1;
   assign bus.valid_o = v3;
   assign bus.luma_o  = luma_q;
   assign bus.user_o  = user3_q;

   // Pick the coefficient set requested by the incoming beat
   always_comb begin
      coef_r = C601_R;
      coef_g = C601_G;
      coef_b = C601_B;
      case (bus.mode_i)
         2'd0: begin
            coef_r = C601_R;
            coef_g = C601_G;
            coef_b = C601_B;
         end
         2'd1: begin
            coef_r = C709_R;
            coef_g = C709_G;
            coef_b = C709_B;
         end
         2'd2: begin
            coef_r = CEQ_R;
            coef_g = CEQ_G;
            coef_b = CEQ_B;
         end
         default: begin
            coef_r = bus.coef_r_i;
            coef_g = bus.coef_g_i;
            coef_b = bus.coef_b_i;
         end
      endcase
   end

   // Stage occupancy; reset empties the whole pipe and discards in-flight beats
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (load1) v1 <= bus.valid_i;
         if (load2) v2 <= v1;
         if (load3) v3 <= v2;
      end
   end

   // Stage 1: per-channel products and sideband, captured on an accepted beat
   always_ff @(posedge clk_i) begin
      if (load1 && bus.valid_i) begin
         prod_r_q <= PROD_W'(bus.red_i)   * PROD_W'(coef_r);
         prod_g_q <= PROD_W'(bus.green_i) * PROD_W'(coef_g);
         prod_b_q <= PROD_W'(bus.blue_i)  * PROD_W'(coef_b);
         user1_q  <= bus.user_i;
      end
   end

   // Stage 2: sum of products, two guard bits so three maxima cannot overflow
   always_ff @(posedge clk_i) begin
      if (load2 && v1) begin
         sum_q   <= SUM_W'(prod_r_q) + SUM_W'(prod_g_q) + SUM_W'(prod_b_q);
         user2_q <= user1_q;
      end
   end

   // Round half up to the integer part, then clip to the largest luma code
   always_comb begin
      unclipped = LUMA_W'((sum_q + ROUND_C) >> COEF_W_P);
      luma_next = unclipped[WIDTH_P-1:0];
      if (unclipped > MAX_C) begin
         luma_next = MAX_C[WIDTH_P-1:0];
      end
   end

   // Stage 3: output registers hold steady while stalled and clear on reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         luma_q  <= '0;
         user3_q <= '0;
      end else if (load3 && v2) begin
         luma_q  <= luma_next;
         user3_q <= user2_q;
      end
   end

endmodule

// File: tb/tb_rgb2luma_pipe.sv
// Scoreboard bench for rgb2luma_pipe: the driver pushes the expected luma and
// sideband of every accepted beat, and an independent monitor pops and
// compares whenever a beat leaves the converter.
`timescale 1ns/1ps
module tb_rgb2luma_pipe;

   localparam int WIDTH_P  = 8;
   localparam int COEF_W_P = 8;
   localparam int USER_W_P = 2;

   typedef struct {
      int luma;
      int user;
      int accept_cycle;
      bit lat_check;
   } exp_beat_t;

   logic clk_i = 1'b0;
   logic rst_i;

   int checks    = 0;
   int failures  = 0;
   int cycle_cnt = 0;
   bit lat_check_en = 1'b0;
   bit rand_ready   = 1'b0;
   exp_beat_t sb_queue[$];

   rgb2luma_pipe_if #(
      .WIDTH_P (WIDTH_P),
      .COEF_W_P(COEF_W_P),
      .USER_W_P(USER_W_P)
   ) bus ();

   rgb2luma_pipe #(
      .WIDTH_P (WIDTH_P),
      .COEF_W_P(COEF_W_P),
      .USER_W_P(USER_W_P)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cycle_cnt <= cycle_cnt + 1;

   // Random downstream backpressure when enabled
   always @(negedge clk_i) begin
      if (rand_ready) bus.ready_i = ($urandom_range(0, 1) == 1);
   end

   // Reference: weighted sum in plain integers, round half up, clip at 255
   function automatic int refLuma(input int mode, input int r, input int g, input int b,
                                  input int cr, input int cg, input int cb);
      int wr, wg, wb, y;
      case (mode)
         0:       begin wr = 77; wg = 150; wb = 29; end
         1:       begin wr = 54; wg = 183; wb = 19; end
         2:       begin wr = 85; wg = 86;  wb = 85; end
         default: begin wr = cr; wg = cg;  wb = cb; end
      endcase
      y = (r * wr + g * wg + b * wb + 128) / 256;
      if (y > 255) y = 255;
      return y;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle_cnt);
      end
   endtask

   // Present one beat from the next falling edge until accepted; expected value
   // comes from the reference model unless a fixed value is supplied
   task automatic applyStimulus(input int mode, input int r, input int g, input int b,
                                input int cr, input int cg, input int cb,
                                input int user, input int exp_fixed);
      int wait_cycles;
      bit done;
      exp_beat_t e;
      @(negedge clk_i);
      bus.valid_i  = 1'b1;
      bus.mode_i   = 2'(mode);
      bus.red_i    = WIDTH_P'(r);
      bus.green_i  = WIDTH_P'(g);
      bus.blue_i   = WIDTH_P'(b);
      bus.coef_r_i = COEF_W_P'(cr);
      bus.coef_g_i = COEF_W_P'(cg);
      bus.coef_b_i = COEF_W_P'(cb);
      bus.user_i   = USER_W_P'(user);
      wait_cycles  = 0;
      done         = 1'b0;
      while (!done) begin
         #4;
         if (bus.ready_o && !rst_i) begin
            e.luma         = (exp_fixed >= 0) ? exp_fixed : refLuma(mode, r, g, b, cr, cg, cb);
            e.user         = user;
            e.accept_cycle = cycle_cnt;
            e.lat_check    = lat_check_en;
            sb_queue.push_back(e);
            done = 1'b1;
            @(posedge clk_i);
            #1;
            bus.valid_i = 1'b0;
         end else begin
            wait_cycles++;
            if (wait_cycles > 1000) begin
               checkOutput("accept_timeout", int'(bus.ready_o), 1);
               bus.valid_i = 1'b0;
               done = 1'b1;
            end else begin
               @(negedge clk_i);
            end
         end
      end
   endtask

   task automatic sendRandom(input int mode, input int user);
      applyStimulus(mode, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    user, -1);
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (sb_queue.size() > 0 && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      checkOutput(name, sb_queue.size(), 0);
   endtask

   // Monitor: compare every departing beat and watch output stability under stall
   initial begin : monitor
      bit hold_valid;
      int held_luma, held_user;
      exp_beat_t e;
      hold_valid = 1'b0;
      forever begin
         @(negedge clk_i);
         #4;
         if (rst_i) begin
            hold_valid = 1'b0;
         end else begin
            if (hold_valid && bus.valid_o) begin
               checkOutput("stall_luma_stable", int'(bus.luma_o), held_luma);
               checkOutput("stall_user_stable", int'(bus.user_o), held_user);
            end
            if (bus.valid_o && bus.ready_i) begin
               hold_valid = 1'b0;
               if (sb_queue.size() == 0) begin
                  checkOutput("unexpected_beat", sb_queue.size(), 1);
               end else begin
                  e = sb_queue.pop_front();
                  checkOutput("luma", int'(bus.luma_o), e.luma);
                  checkOutput("user", int'(bus.user_o), e.user);
                  if (e.lat_check) checkOutput("latency", cycle_cnt - e.accept_cycle, 3);
               end
            end else if (bus.valid_o) begin
               hold_valid = 1'b1;
               held_luma  = int'(bus.luma_o);
               held_user  = int'(bus.user_o);
            end else begin
               hold_valid = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #950000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      bus.valid_i  = 1'b0;
      bus.ready_i  = 1'b1;
      bus.mode_i   = '0;
      bus.red_i    = '0;
      bus.green_i  = '0;
      bus.blue_i   = '0;
      bus.coef_r_i = '0;
      bus.coef_g_i = '0;
      bus.coef_b_i = '0;
      bus.user_i   = '0;
      rst_i        = 1'b1;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      #4;
      checkOutput("reset_valid_o", int'(bus.valid_o), 0);
      checkOutput("reset_ready_o", int'(bus.ready_o), 1);
      checkOutput("reset_luma_o",  int'(bus.luma_o),  0);
      checkOutput("reset_user_o",  int'(bus.user_o),  0);

      // Directed values with fixed expectations, streamed back-to-back
      lat_check_en = 1'b1;
      applyStimulus(0, 255,   0,   0,   0,   0,   0, 1,  77);
      applyStimulus(0, 255, 255, 255,   0,   0,   0, 2, 255);
      applyStimulus(0,   0,   0,   0,   0,   0,   0, 3,   0);
      applyStimulus(1,   0, 200,   0,   0,   0,   0, 0, 143);
      applyStimulus(2,  90,  90,  90,   0,   0,   0, 1,  90);
      applyStimulus(3, 255, 255, 255, 200, 200, 200, 2, 255);
      applyStimulus(3,   3,   0,   0, 128,   0,   0, 3,   2);
      waitDrain("directed_drain");

      // Backpressure: three beats fill the pipe, the rest wait for release
      lat_check_en = 1'b0;
      @(negedge clk_i);
      bus.ready_i = 1'b0;
      for (int i = 0; i < 3; i++) sendRandom(i, i);
      @(negedge clk_i);
      #4;
      checkOutput("bp_ready_low", int'(bus.ready_o), 0);
      checkOutput("bp_valid_high", int'(bus.valid_o), 1);
      fork
         begin
            for (int k = 3; k < 6; k++) sendRandom(k % 4, k % 4);
         end
         begin
            repeat (4) @(negedge clk_i);
            bus.ready_i = 1'b1;
         end
      join
      waitDrain("bp_drain");

      // Random traffic with random gaps and random backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         while ($urandom_range(0, 1) == 1) @(negedge clk_i);
         sendRandom($urandom_range(0, 3), $urandom_range(0, 3));
      end
      rand_ready = 1'b0;
      @(negedge clk_i);
      bus.ready_i = 1'b1;
      waitDrain("random_drain");

      // Reset with three beats in flight; none of them may emerge
      @(negedge clk_i);
      bus.ready_i = 1'b0;
      for (int i = 0; i < 3; i++) sendRandom($urandom_range(0, 3), i);
      @(negedge clk_i);
      rst_i = 1'b1;
      sb_queue.delete();
      @(negedge clk_i);
      rst_i = 1'b0;
      #4;
      checkOutput("midreset_valid_o", int'(bus.valid_o), 0);
      checkOutput("midreset_ready_o", int'(bus.ready_o), 1);
      checkOutput("midreset_luma_o",  int'(bus.luma_o),  0);
      @(negedge clk_i);
      bus.ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #4;
         checkOutput("no_stale_beat", int'(bus.valid_o), 0);
         @(negedge clk_i);
      end
      lat_check_en = 1'b1;
      sendRandom(1, 2);
      waitDrain("post_reset_drain");

      repeat (3) @(negedge clk_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
